// File: rtl/jpeg_bitstream_burst_ctrl.sv
// Read-side burst scheduler for the JPEG bitstream FIFO.
// Turns the FIFO water level into fixed-length write bursts and pops
// exactly the granted words through a 4-entry output skid buffer.
// frame_end arms a delayed flush that drains the residue as one short
// burst and then pulses frame_done.
module jpeg_bitstream_burst_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEVEL_WIDTH = 10,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int SETTLE_CYC  = 8,
  parameter int FCNT_WIDTH  = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rempty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic                   frame_start,
  input  logic                   frame_end,
  output logic                   burst_req,
  output logic [ADDR_WIDTH-1:0]  burst_addr,
  output logic [7:0]             burst_len,
  input  logic                   burst_ack,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   frame_done,
  output logic [FCNT_WIDTH-1:0]  frame_words,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam logic [LEVEL_WIDTH-1:0] BL_LVL = LEVEL_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t                         state_q, state_d;
  logic [7:0]                     len_q, len_d;
  logic [7:0]                     pop_left_q, pop_left_d;
  logic [7:0]                     emit_left_q, emit_left_d;
  logic [ADDR_WIDTH-1:0]          cur_addr_q, cur_addr_d;
  logic                           burst_req_q, burst_req_d;
  logic                           inflight_q, inflight_d;
  logic [3:0][DATA_WIDTH-1:0]     mem_q, mem_d;
  logic [1:0]                     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]                     occ_q, occ_d;
  logic                           flush_pend_q, flush_pend_d;
  logic [SW-1:0]                  settle_q, settle_d;
  logic [FCNT_WIDTH-1:0]          fwords_q, fwords_d;
  logic                           ferr_q, ferr_d;
  logic                           fdone_q, fdone_d;

  logic pop, accept, armed;

  // Pop only while the buffer plus the word in flight leaves room; the
  // pop is gated by rst_n so a reset mid-burst stops reads immediately.
  always_comb begin
    pop = rst_n && (state_q == XFER) && (pop_left_q != 8'd0) && !fifo_rempty &&
          ((occ_q + {2'b0, inflight_q}) <= 3'd2);
  end

  assign out_valid   = (occ_q != 3'd0);
  assign accept      = out_valid && out_ready;
  assign out_last    = out_valid && (emit_left_q == 8'd1);
  assign out_data    = mem_q[rptr_q];
  assign armed       = flush_pend_q && (settle_q == '0);
  assign fifo_rd_en  = pop;
  assign burst_req   = burst_req_q;
  assign burst_addr  = cur_addr_q;
  assign burst_len   = len_q;
  assign frame_done  = fdone_q;
  assign frame_words = fwords_q;
  assign frame_err   = ferr_q;
  // DONE is the completion cycle itself: the flush is already disarmed,
  // so busy drops in the same cycle frame_done is high.
  assign busy        = (state_q == REQ) || (state_q == XFER) || flush_pend_q;

  // Next-state: skid buffer, flush timer, frame bookkeeping and scheduler FSM.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pop_left_d   = pop_left_q;
    emit_left_d  = emit_left_q;
    cur_addr_d   = cur_addr_q;
    burst_req_d  = burst_req_q;
    inflight_d   = pop;
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    flush_pend_d = flush_pend_q;
    settle_d     = settle_q;
    fwords_d     = fwords_q;
    ferr_d       = ferr_q;
    fdone_d      = 1'b0;

    // FIFO data lands one cycle after the pop strobe
    if (inflight_q) begin
      mem_d[wptr_q] = fifo_rd_data;
      wptr_d        = wptr_q + 2'd1;
    end
    if (accept) begin
      rptr_d      = rptr_q + 2'd1;
      emit_left_d = emit_left_q - 8'd1;
      fwords_d    = fwords_q + FCNT_WIDTH'(1);
    end
    occ_d = occ_q + {2'b0, inflight_q} - {2'b0, accept};
    if (pop) pop_left_d = pop_left_q - 8'd1;

    // the level is not trusted for flushing until the settle timer expires
    if (flush_pend_q && (settle_q != '0)) settle_d = settle_q - SW'(1);
    if (frame_end && !flush_pend_q) begin
      flush_pend_d = 1'b1;
      settle_d     = SW'(SETTLE_CYC);
    end

    if (frame_start) begin
      if ((state_q == IDLE) && !flush_pend_q) begin
        cur_addr_d = cfg_base_addr;
        fwords_d   = '0;
      end else begin
        ferr_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fifo_rd_level >= BL_LVL) begin
          state_d     = REQ;
          len_d       = 8'(BURST_LEN);
          burst_req_d = 1'b1;
        end else if (armed && (fifo_rd_level != '0)) begin
          // level is below BURST_LEN here, so min() is the level itself
          state_d     = REQ;
          len_d       = 8'(fifo_rd_level);
          burst_req_d = 1'b1;
        end else if (armed && fifo_rempty) begin
          state_d      = DONE;
          flush_pend_d = 1'b0;
          fdone_d      = 1'b1;
        end
      end
      REQ: begin
        if (burst_ack) begin
          state_d     = XFER;
          burst_req_d = 1'b0;
          pop_left_d  = len_q;
          emit_left_d = len_q;
        end
      end
      XFER: begin
        if (accept && out_last) begin
          state_d    = IDLE;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(BPW);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards the buffer and clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      pop_left_q   <= '0;
      emit_left_q  <= '0;
      cur_addr_q   <= '0;
      burst_req_q  <= 1'b0;
      inflight_q   <= 1'b0;
      mem_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
      flush_pend_q <= 1'b0;
      settle_q     <= '0;
      fwords_q     <= '0;
      ferr_q       <= 1'b0;
      fdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pop_left_q   <= pop_left_d;
      emit_left_q  <= emit_left_d;
      cur_addr_q   <= cur_addr_d;
      burst_req_q  <= burst_req_d;
      inflight_q   <= inflight_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      flush_pend_q <= flush_pend_d;
      settle_q     <= settle_d;
      fwords_q     <= fwords_d;
      ferr_q       <= ferr_d;
      fdone_q      <= fdone_d;
    end
  end

endmodule
